// File: rtl/aes_crypt_ctrl_if.sv
// Control bundle between the AES crypt controller (master) and the host/datapath/key-schedule side (slave).
interface aes_crypt_ctrl_if;
  logic       start;
  logic       mode;
  logic       din_vld;
  logic       din_rdy;
  logic       dout_vld;
  logic       dout_rdy;
  logic       key_rdy;
  logic [3:0] key_idx;
  logic [1:0] keyadsel;
  logic       mixsel;
  logic       reginsel;
  logic       shiftsel;
  logic       wrregen;
  logic       busy;
  logic       done;

  modport master (
    input  start, mode, din_vld, dout_rdy, key_rdy,
    output din_rdy, dout_vld, key_idx, keyadsel, mixsel, reginsel,
           shiftsel, wrregen, busy, done
  );

  modport slave (
    output start, mode, din_vld, dout_rdy, key_rdy,
    input  din_rdy, dout_vld, key_idx, keyadsel, mixsel, reginsel,
           shiftsel, wrregen, busy, done
  );
endinterface

// File: rtl/aes_crypt_ctrl.sv
// Control FSM for the byte-serial AES-128 datapath: load 16 bytes, run NR+1 rounds, unload 16 bytes.
// Optional macro OVERLAP_LOAD_EN: shift the next block in while the current result shifts out.
module aes_crypt_ctrl #(
  parameter int NR = 10,
  parameter int NB = 16
) (
  input logic             clk,
  input logic             rst,
  aes_crypt_ctrl_if.master bus
);
  localparam int BW = $clog2(NB);
  localparam int RW = $clog2(NR + 1);
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [RW-1:0] RLAST = RW'(NR);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KWAIT, S_ROUND, S_UNLOAD} state_t;

  state_t        r_state, w_nstate;
  logic [BW-1:0] r_bcnt;
  logic [RW-1:0] r_rcnt;
  logic          r_mode;
  logic          r_done;
  logic          w_ul_beat;

`ifdef OVERLAP_LOAD_EN
  assign w_ul_beat = bus.din_vld & bus.dout_rdy;
`else
  assign w_ul_beat = bus.dout_rdy;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_rcnt  <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_mode <= bus.mode;
          r_bcnt <= '0;
        end
        S_LOAD: if (bus.din_vld) r_bcnt <= (r_bcnt == BLAST) ? '0 : r_bcnt + 1'b1;
        S_KWAIT: if (bus.key_rdy) r_rcnt <= '0;
        S_ROUND: begin
          r_rcnt <= r_rcnt + 1'b1;
          if (r_rcnt == RLAST) r_bcnt <= '0;
        end
        S_UNLOAD: if (w_ul_beat) begin
          if (r_bcnt == BLAST) begin
            r_bcnt <= '0;
            r_done <= 1'b1;
`ifdef OVERLAP_LOAD_EN
            // next block's bytes are already in; take its mode now
            r_mode <= bus.mode;
`endif
          end else begin
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nstate     = r_state;
    bus.din_rdy  = 1'b0;
    bus.dout_vld = 1'b0;
    bus.key_idx  = 4'd0;
    bus.keyadsel = 2'd0;
    bus.mixsel   = 1'b0;
    bus.reginsel = 1'b0;
    bus.shiftsel = 1'b0;
    bus.wrregen  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) w_nstate = S_LOAD;
      S_LOAD: begin
        bus.din_rdy  = 1'b1;
        bus.shiftsel = 1'b1;
        bus.wrregen  = bus.din_vld;
        if (bus.din_vld && r_bcnt == BLAST) w_nstate = S_KWAIT;
      end
      S_KWAIT: if (bus.key_rdy) w_nstate = S_ROUND;
      S_ROUND: begin
        bus.wrregen = 1'b1;
        if (!r_mode) begin
          bus.key_idx = 4'(r_rcnt);
          if (r_rcnt == RLAST)   bus.keyadsel = 2'd2;
          else if (r_rcnt != '0) bus.keyadsel = 2'd1;
        end else begin
          // decrypt walks the key schedule backwards through the g path
          if (r_rcnt == '0) begin
            bus.key_idx = 4'(NR);
          end else if (r_rcnt == RLAST) begin
            bus.keyadsel = 2'd3;
          end else begin
            bus.mixsel   = 1'b1;
            bus.reginsel = 1'b1;
            bus.key_idx  = 4'(RLAST - r_rcnt);
          end
        end
        if (r_rcnt == RLAST) w_nstate = S_UNLOAD;
      end
      S_UNLOAD: begin
`ifdef OVERLAP_LOAD_EN
        bus.dout_vld = bus.din_vld;
        bus.din_rdy  = bus.dout_rdy;
`else
        bus.dout_vld = 1'b1;
`endif
        bus.shiftsel = 1'b1;
        bus.wrregen  = w_ul_beat;
        if (w_ul_beat && r_bcnt == BLAST) begin
`ifdef OVERLAP_LOAD_EN
          w_nstate = S_KWAIT;
`else
          w_nstate = S_IDLE;
`endif
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
endmodule
